kpt_out_streamer: RTL and testbench
===================================

# kpt_out_streamer

Serializes detected keypoints onto the core's 16-bit output port (`out_valid`/`out_data`) after keypoint detection finishes. On a start pulse driven by `detect_filter_done`, it reads the layer-1 keypoint memory and then the layer-2 keypoint memory. It emits a framed word stream that the testbench or host reads back. This block is the transmit-side counterpart of the bench's keypoint readback, and it replaces hierarchical peeking into `keypoint_1_mem`/`keypoint_2_mem`.

## Interface
Parameters:
- `KP_ADDR_W`, default 12: keypoint memory address width.
- `KP_DEPTH`, default 4096: entries per keypoint memory; must be at most 2^KP_ADDR_W.

Ports:
- `clk`  in  1: the single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle pulse, connected to `detect_filter_done`.
- `kp1_count`  in  13: number of valid layer-1 entries.
- `kp2_count`  in  13: number of valid layer-2 entries.
- `kp1_addr`  out  KP_ADDR_W: layer-1 memory read address.
- `kp1_rdata`  in  19: layer-1 entry; `{row[18:10], col[9:0]}`.
- `kp2_addr`  out  KP_ADDR_W: layer-2 memory read address.
- `kp2_rdata`  in  19: layer-2 entry; same format as `kp1_rdata`.
- `out_valid`  out  1: `out_data` holds a frame word this cycle.
- `out_data`  out  16: frame word.
- `busy`  out  1: a frame is in progress.
- `done`  out  1: one-cycle pulse after the last frame word.

## Operation
- Memories are synchronous read: the address applied at edge t gives data valid after edge t+1.
- Frame format, in order:
  - H1 = `{2'b10, 1'b0, n1[12:0]}`.
  - n1 pairs of `{7'b0, row}` then `{6'b0, col}` from layer 1.
  - H2 = `{2'b10, 1'b1, n2[12:0]}`.
  - n2 pairs from layer 2, same format.
  - Optional checksum word (see Configuration).
- n1 and n2 are `kp1_count` and `kp2_count` latched at start. A value above `KP_DEPTH` saturates to `KP_DEPTH`.
- States: IDLE, HDR1, ROW1, COL1, HDR2, ROW2, COL2, CSUM, FIN.
  - IDLE to HDR1 on `start`. Counts are latched and address 0 is issued to both memories.
  - HDR1 to ROW1 if n1>0, else to HDR2.
  - ROW1 to COL1. In COL1, the address increments to prefetch the next entry.
  - COL1 to ROW1 while entries remain, else to HDR2.
  - Layer 2 repeats the same pattern (HDR2, ROW2, COL2).
  - After the last layer-2 word: go to CSUM if the macro is enabled, else to FIN.
  - FIN pulses `done` and returns to IDLE.
- The row and col words of one entry come from a single captured read. The memory is not re-read between them.
- `start` while `busy` is ignored.
- Addresses stop at `KP_DEPTH`-1; they never wrap into stale entries.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, `kp1_addr`=0, `kp2_addr`=0, state IDLE.
- `out_valid`, `out_data` and `done` are registered.
- `start` sampled high at edge k: H1 is valid after edge k+1, and `busy` goes high after edge k.
- Words are strictly back-to-back: `out_valid` stays high for exactly 2+2(n1+n2) cycles, plus 1 with checksum. There is no backpressure.
- `done` is high for the cycle immediately after the last word, with `out_valid`=0. `busy` falls at that same edge.
- A new `start` is accepted in the cycle `done` is high or later.
- Asserting `rst_n` low mid-frame drops all outputs to their reset values immediately (asynchronously). No partial frame resumes after reset.

## Configuration
- Macro `KPT_OUT_CHECKSUM_EN`.
- Defined: the CSUM state appends one word, the modulo-2^16 sum of every preceding word of the frame (headers included).
- Undefined: there is no CSUM state or checksum adder, and the frame ends after the last layer-2 word (or after H2).

## Test plan
- n1=0, n2=0, macro off: start → exactly 2 words, 0x8000 then 0xA000; `done` high one cycle later.
- n1=1 (row=5, col=7), n2=0, macro on: words 0x8001, 0x0005, 0x0007, 0xA000, 0x200D; `done` next cycle.
- n1=3, n2=2 with distinct known entries: 12 contiguous words with rows/cols in memory order; addresses advance 0..2 and 0..1 with no gaps in `out_valid`.
- kp1_count=5000, KP_DEPTH=4096: H1 = 0x9000, 4096 pairs follow, and `kp1_addr` never exceeds 4095.
- Second `start` pulse mid-frame: ignored, with frame length and content unchanged. `rst_n` pulsed low mid-frame: `out_valid` drops to 0 at once, `busy`=0, and a fresh start afterwards produces a complete frame.

Source files
------------

// File: rtl/kpt_out_streamer.sv
// -----------------------------------------------------------------------------
// kpt_out_streamer
//
// Purpose:
//   Once keypoint detection finishes, this block reads the layer-1 keypoint
//   memory and then the layer-2 keypoint memory. It sends their contents out
//   as a framed 16-bit word stream.
//
//   Frame layout:
//     H1 = {2'b10, 1'b0, n1}
//     n1 x ({7'b0, row}, {6'b0, col})      layer-1 entries in memory order
//     H2 = {2'b10, 1'b1, n2}
//     n2 x ({7'b0, row}, {6'b0, col})      layer-2 entries in memory order
//     [checksum]                          only with KPT_OUT_CHECKSUM_EN
//
// Configuration macro:
//   KPT_OUT_CHECKSUM_EN - when defined, the frame ends with one extra word.
//                         That word is the modulo-2^16 sum of every
//                         preceding word of the frame.
//
// Ports:
//   clk        in   1          clock
//   rst_n      in   1          asynchronous active-low reset
//   start      in   1          one-cycle start pulse (detect_filter_done)
//   kp1_count  in   13         valid layer-1 entries (saturates at KP_DEPTH)
//   kp2_count  in   13         valid layer-2 entries (saturates at KP_DEPTH)
//   kp1_addr   out  KP_ADDR_W  layer-1 memory read address (registered)
//   kp1_rdata  in   19         layer-1 entry {row[18:10], col[9:0]}
//   kp2_addr   out  KP_ADDR_W  layer-2 memory read address (registered)
//   kp2_rdata  in   19         layer-2 entry {row[18:10], col[9:0]}
//   out_valid  out  1          out_data holds a frame word
//   out_data   out  16         frame word
//   busy       out  1          a frame is in progress
//   done       out  1          one-cycle pulse after the last frame word
// -----------------------------------------------------------------------------
module kpt_out_streamer #(
  parameter int unsigned KP_ADDR_W = 12,
  parameter int unsigned KP_DEPTH  = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [12:0]          kp1_count,
  input  logic [12:0]          kp2_count,
  output logic [KP_ADDR_W-1:0] kp1_addr,
  input  logic [18:0]          kp1_rdata,
  output logic [KP_ADDR_W-1:0] kp2_addr,
  input  logic [18:0]          kp2_rdata,
  output logic                 out_valid,
  output logic [15:0]          out_data,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CNT_W  = 13;
  localparam int unsigned WORD_W = 16;

`ifdef KPT_OUT_CHECKSUM_EN
  typedef enum logic [3:0] {
    S_IDLE, S_HDR1, S_ROW1, S_COL1, S_HDR2, S_ROW2, S_COL2, S_CSUM, S_FIN
  } state_t;
  // State entered after the last layer-2 word (or after H2 when n2 = 0).
  localparam state_t S_TAIL = S_CSUM;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_HDR1, S_ROW1, S_COL1, S_HDR2, S_ROW2, S_COL2, S_FIN
  } state_t;
  localparam state_t S_TAIL = S_FIN;
`endif

  state_t              r_state;
  logic [CNT_W-1:0]    r_rem1;     // layer-1 entries not yet emitted (holds n1 in HDR1)
  logic [CNT_W-1:0]    r_rem2;     // layer-2 entries not yet emitted (holds n2 in HDR2)
  logic [9:0]          r_col;      // col half of the entry captured in ROWx
  logic                w_emit;
  logic [WORD_W-1:0]   w_word;
`ifdef KPT_OUT_CHECKSUM_EN
  logic [WORD_W-1:0]   r_csum;
`endif

  // Clamp a requested count to the memory depth.
  function automatic logic [CNT_W-1:0] f_sat(input logic [CNT_W-1:0] c);
    if (32'(c) > KP_DEPTH) f_sat = CNT_W'(KP_DEPTH);
    else                   f_sat = c;
  endfunction

  // The word presented at the next edge depends only on the current state.
  // The row word comes straight from the memory read. The col word uses the
  // copy captured during that same read.
  always_comb begin
    w_emit = 1'b0;
    w_word = '0;
    case (r_state)
      S_HDR1: begin
        w_emit = 1'b1;
        w_word = {2'b10, 1'b0, r_rem1};
      end
      S_ROW1: begin
        w_emit = 1'b1;
        w_word = {7'b0, kp1_rdata[18:10]};
      end
      S_COL1: begin
        w_emit = 1'b1;
        w_word = {6'b0, r_col};
      end
      S_HDR2: begin
        w_emit = 1'b1;
        w_word = {2'b10, 1'b1, r_rem2};
      end
      S_ROW2: begin
        w_emit = 1'b1;
        w_word = {7'b0, kp2_rdata[18:10]};
      end
      S_COL2: begin
        w_emit = 1'b1;
        w_word = {6'b0, r_col};
      end
`ifdef KPT_OUT_CHECKSUM_EN
      S_CSUM: begin
        w_emit = 1'b1;
        w_word = r_csum;
      end
`endif
      default: begin
        w_emit = 1'b0;
        w_word = '0;
      end
    endcase
  end

  // Frame sequencer: state, counters, read addresses and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rem1    <= '0;
      r_rem2    <= '0;
      r_col     <= '0;
      kp1_addr  <= '0;
      kp2_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef KPT_OUT_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      out_valid <= w_emit;
      out_data  <= w_word;
      done      <= 1'b0;
`ifdef KPT_OUT_CHECKSUM_EN
      if (w_emit) r_csum <= r_csum + w_word;
`endif

      case (r_state)
        S_IDLE: begin
          // Address 0 goes to both memories now, so the first entry of
          // each layer is already readable when its ROW state is reached.
          if (start) begin
            r_state  <= S_HDR1;
            busy     <= 1'b1;
            r_rem1   <= f_sat(kp1_count);
            r_rem2   <= f_sat(kp2_count);
            kp1_addr <= '0;
            kp2_addr <= '0;
`ifdef KPT_OUT_CHECKSUM_EN
            r_csum   <= '0;
`endif
          end
        end

        S_HDR1: r_state <= (r_rem1 != '0) ? S_ROW1 : S_HDR2;

        S_ROW1: begin
          // Capture the col half and request the next entry right away.
          // The read is then ready one cycle later, when ROW1 is entered again.
          r_col   <= kp1_rdata[9:0];
          r_rem1  <= r_rem1 - CNT_W'(1);
          if (r_rem1 > CNT_W'(1) && 32'(kp1_addr) < KP_DEPTH - 1)
            kp1_addr <= kp1_addr + KP_ADDR_W'(1);
          r_state <= S_COL1;
        end

        S_COL1: r_state <= (r_rem1 != '0) ? S_ROW1 : S_HDR2;

        S_HDR2: r_state <= (r_rem2 != '0) ? S_ROW2 : S_TAIL;

        S_ROW2: begin
          r_col   <= kp2_rdata[9:0];
          r_rem2  <= r_rem2 - CNT_W'(1);
          if (r_rem2 > CNT_W'(1) && 32'(kp2_addr) < KP_DEPTH - 1)
            kp2_addr <= kp2_addr + KP_ADDR_W'(1);
          r_state <= S_COL2;
        end

        S_COL2: r_state <= (r_rem2 != '0) ? S_ROW2 : S_TAIL;

`ifdef KPT_OUT_CHECKSUM_EN
        S_CSUM: r_state <= S_FIN;
`endif

        S_FIN: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kpt_out_streamer.sv
// -----------------------------------------------------------------------------
// tb_kpt_out_streamer
//
// Purpose: directed, self-checking bench for kpt_out_streamer. It uses
// behavioural synchronous-read keypoint memories and hand-computed frames.
// With KPT_OUT_CHECKSUM_EN defined, the expected frames include the
// checksum word.
// -----------------------------------------------------------------------------
module tb_kpt_out_streamer;

  localparam int unsigned KP_ADDR_W = 12;
  localparam int unsigned KP_DEPTH  = 4096;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [12:0]          kp1_count = '0;
  logic [12:0]          kp2_count = '0;
  logic [KP_ADDR_W-1:0] kp1_addr;
  logic [KP_ADDR_W-1:0] kp2_addr;
  logic [18:0]          kp1_rdata = '0;
  logic [18:0]          kp2_rdata = '0;
  logic                 out_valid;
  logic [15:0]          out_data;
  logic                 busy;
  logic                 done;

  logic [18:0] mem1 [KP_DEPTH];
  logic [18:0] mem2 [KP_DEPTH];

  logic [15:0] exp_q [$];
  logic [15:0] got_q [$];

  int n_tests = 0;
  int n_fail  = 0;

  kpt_out_streamer #(.KP_ADDR_W(KP_ADDR_W), .KP_DEPTH(KP_DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .kp1_count (kp1_count),
    .kp2_count (kp2_count),
    .kp1_addr  (kp1_addr),
    .kp1_rdata (kp1_rdata),
    .kp2_addr  (kp2_addr),
    .kp2_rdata (kp2_rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read keypoint memories.
  always @(posedge clk) begin
    kp1_rdata <= mem1[kp1_addr];
    kp2_rdata <= mem2[kp2_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int c);
    return (c > int'(KP_DEPTH)) ? int'(KP_DEPTH) : c;
  endfunction

  // Build the expected frame from the memory contents.
  task automatic build_exp(input int c1, input int c2);
    int n1;
    int n2;
    n1 = sat(c1);
    n2 = sat(c2);
    exp_q.delete();
    exp_q.push_back({2'b10, 1'b0, 13'(n1)});
    for (int i = 0; i < n1; i++) begin
      exp_q.push_back({7'b0, mem1[i][18:10]});
      exp_q.push_back({6'b0, mem1[i][9:0]});
    end
    exp_q.push_back({2'b10, 1'b1, 13'(n2)});
    for (int i = 0; i < n2; i++) begin
      exp_q.push_back({7'b0, mem2[i][18:10]});
      exp_q.push_back({6'b0, mem2[i][9:0]});
    end
    add_csum();
  endtask

  task automatic add_csum();
`ifdef KPT_OUT_CHECKSUM_EN
    logic [15:0] s;
    s = '0;
    foreach (exp_q[i]) s = s + exp_q[i];
    exp_q.push_back(s);
`endif
  endtask

  // Pulse start, then collect the frame and compare it against exp_q.
  // If inject >= 0, a second start pulse is driven at that collection cycle.
  task automatic run_frame(input int c1, input int c2, input int inject, input string tag);
    int bound;
    int done_at;
    int first_v;
    int last_v;
    int gaps;
    int max1;
    int max2;
    logic done_v;
    logic done_b;
    logic [31:0] obs;
    @(negedge clk);
    kp1_count = 13'(c1);
    kp2_count = 13'(c2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
    chk({tag, " valid_before_h1"}, 32'(out_valid), 32'd0);
    got_q.delete();
    bound   = 2 * (sat(c1) + sat(c2)) + 12;
    done_at = -1;
    first_v = -1;
    last_v  = -1;
    gaps    = 0;
    max1    = 0;
    max2    = 0;
    done_v  = 1'b1;
    done_b  = 1'b1;
    for (int cyc = 0; cyc < bound && done_at < 0; cyc++) begin
      start = (cyc == inject);
      @(negedge clk);
      if (int'(kp1_addr) > max1) max1 = int'(kp1_addr);
      if (int'(kp2_addr) > max2) max2 = int'(kp2_addr);
      if (out_valid === 1'b1) begin
        if (first_v < 0) first_v = cyc;
        if (last_v >= 0 && last_v != cyc - 1) gaps++;
        last_v = cyc;
        got_q.push_back(out_data);
      end
      if (done === 1'b1) begin
        done_at = cyc;
        done_v  = out_valid;
        done_b  = busy;
      end
    end
    start = 1'b0;
    chk({tag, " done_seen_in_budget"}, 32'(done_at >= 0), 32'd1);
    chk({tag, " first_word_latency"}, 32'(first_v), 32'd0);
    chk({tag, " word_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    chk({tag, " valid_gaps"}, 32'(gaps), 32'd0);
    chk({tag, " done_cycle"}, 32'(done_at), 32'(exp_q.size()));
    chk({tag, " valid_low_at_done"}, 32'(done_v), 32'd0);
    chk({tag, " busy_low_at_done"}, 32'(done_b), 32'd0);
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD_BEEF;
      chk($sformatf("%s word%0d", tag, i), obs, 32'(exp_q[i]));
    end
    chk({tag, " kp1_addr_max"}, 32'(max1), 32'((sat(c1) == 0) ? 0 : sat(c1) - 1));
    chk({tag, " kp2_addr_max"}, 32'(max2), 32'((sat(c2) == 0) ? 0 : sat(c2) - 1));
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(KP_DEPTH); i++) begin
      mem1[i] = {9'(i % 512), 10'((i * 7 + 3) % 1024)};
      mem2[i] = {9'((i * 3 + 100) % 512), 10'(1023 - (i % 1024))};
    end
    mem1[0] = {9'd5,   10'd7};
    mem1[1] = {9'd300, 10'd1000};
    mem1[2] = {9'd511, 10'd1};
    mem2[0] = {9'd17,  10'd512};
    mem2[1] = {9'd256, 10'd33};

    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset kp1_addr", 32'(kp1_addr), 32'd0);
    chk("reset kp2_addr", 32'(kp2_addr), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Empty frame: headers only.
    exp_q = '{16'h8000, 16'hA000};
`ifdef KPT_OUT_CHECKSUM_EN
    exp_q.push_back(16'h2000);
`endif
    run_frame(0, 0, -1, "empty");

    // One layer-1 entry (row 5, col 7).
    exp_q = '{16'h8001, 16'h0005, 16'h0007, 16'hA000};
`ifdef KPT_OUT_CHECKSUM_EN
    exp_q.push_back(16'h200D);
`endif
    run_frame(1, 0, -1, "one");

    // Three layer-1 and two layer-2 entries.
    exp_q = '{16'h8003, 16'h0005, 16'h0007, 16'h012C, 16'h03E8, 16'h01FF, 16'h0001,
              16'hA002, 16'h0011, 16'h0200, 16'h0100, 16'h0021};
`ifdef KPT_OUT_CHECKSUM_EN
    exp_q.push_back(16'h2A57);
`endif
    run_frame(3, 2, -1, "mixed");

    // Layer 1 empty, layer 2 populated.
    build_exp(0, 4);
    run_frame(0, 4, -1, "l2only");

    // Second start mid-frame must be ignored.
    exp_q = '{16'h8003, 16'h0005, 16'h0007, 16'h012C, 16'h03E8, 16'h01FF, 16'h0001,
              16'hA002, 16'h0011, 16'h0200, 16'h0100, 16'h0021};
`ifdef KPT_OUT_CHECKSUM_EN
    exp_q.push_back(16'h2A57);
`endif
    run_frame(3, 2, 4, "restart_ignored");

    // Count above depth saturates.
    build_exp(5000, 0);
    run_frame(5000, 0, -1, "saturate");
    chk("saturate header", 32'(got_q.size() > 0 ? got_q[0] : 16'h0), 32'h9000);

    // Asynchronous reset mid-frame.
    @(negedge clk);
    kp1_count = 13'd3;
    kp2_count = 13'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst valid_before", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst out_data", 32'(out_data), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst kp1_addr", 32'(kp1_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst no_resume", 32'(out_valid), 32'd0);
    exp_q = '{16'h8003, 16'h0005, 16'h0007, 16'h012C, 16'h03E8, 16'h01FF, 16'h0001,
              16'hA002, 16'h0011, 16'h0200, 16'h0100, 16'h0021};
`ifdef KPT_OUT_CHECKSUM_EN
    exp_q.push_back(16'h2A57);
`endif
    run_frame(3, 2, -1, "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
